// File: rtl/drv_pwm_ramp.sv
`default_nettype none
// ============================================================================
// Module   : drv_pwm_ramp
// Function : Duty-value sequencer that ramps the PWM duty toward a requested
//            target in fixed steps, updating only on PWM period boundaries.
// Revision : 1.0
// ============================================================================
module drv_pwm_ramp #(
  parameter int p_depth  = 10,
  parameter int p_step_w = 4,
  parameter int p_hold_w = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [p_depth-1:0]  i_target,
  input  logic [p_step_w-1:0] i_step,
  input  logic [p_hold_w-1:0] i_hold,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [p_depth-1:0]  o_val,
  output logic                o_busy,
  output logic                o_done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic [p_depth-1:0]  r_cnt;
  logic [p_depth-1:0]  r_val,      w_val_nxt;
  logic [p_depth-1:0]  r_target,   w_target_nxt;
  logic [p_step_w-1:0] r_step,     w_step_nxt;
  logic [p_hold_w-1:0] r_hold,     w_hold_nxt;
  logic [p_hold_w-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic                r_done,     w_done_nxt;
  logic                w_tick;
  logic                w_xfer;
  logic                w_up;
  logic [p_depth:0]    w_dist;
  logic [p_depth:0]    w_step_ext;

  // Tick marks the last clock of each PWM period, so an update lands on count 0.
  assign w_tick     = &r_cnt;
  assign w_xfer     = i_valid && (r_state == S_IDLE);
  assign w_up       = (r_target > r_val);
  assign w_dist     = w_up ? ({1'b0, r_target} - {1'b0, r_val})
                           : ({1'b0, r_val} - {1'b0, r_target});
  assign w_step_ext = (p_depth+1)'(r_step);

  always_comb begin
    w_state_nxt    = r_state;
    w_val_nxt      = r_val;
    w_target_nxt   = r_target;
    w_step_nxt     = r_step;
    w_hold_nxt     = r_hold;
    w_hold_cnt_nxt = r_hold_cnt;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_target_nxt   = i_target;
          w_step_nxt     = (i_step == '0) ? (p_step_w)'(1) : i_step;
          w_hold_nxt     = i_hold;
          w_hold_cnt_nxt = '0;
          if (i_target == r_val) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RAMP;
          end
        end
      end
      S_RAMP: begin
        if (w_tick) begin
          if (r_hold_cnt < r_hold) begin
            w_hold_cnt_nxt = r_hold_cnt + (p_hold_w)'(1);
          end else begin
            w_hold_cnt_nxt = '0;
            // Clamp the final step onto the target so the ramp cannot overshoot or wrap.
            if (w_dist <= w_step_ext) begin
              w_val_nxt   = r_target;
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end else if (w_up) begin
              w_val_nxt = r_val + (p_depth)'(r_step);
            end else begin
              w_val_nxt = r_val - (p_depth)'(r_step);
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_val      <= '0;
      r_target   <= '0;
      r_step     <= '0;
      r_hold     <= '0;
      r_hold_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= r_cnt + (p_depth)'(1);
      r_val      <= w_val_nxt;
      r_target   <= w_target_nxt;
      r_step     <= w_step_nxt;
      r_hold     <= w_hold_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_ready = (r_state == S_IDLE);
  assign o_busy  = (r_state == S_RAMP);
  assign o_val   = r_val;
  assign o_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_drv_pwm_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_drv_pwm_ramp
// Function : Directed, table-driven bench for the PWM duty ramp sequencer.
// Revision : 1.0
// ============================================================================
module tb_drv_pwm_ramp;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [9:0] target;
  logic [3:0] step;
  logic [7:0] hold;
  logic       ready;
  logic [9:0] val;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;
  int tb_cnt = 0;
  bit last_tick = 1'b0;

  drv_pwm_ramp #(
    .p_depth (10),
    .p_step_w(4),
    .p_hold_w(8)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_target(target),
    .i_step  (step),
    .i_hold  (hold),
    .i_valid (valid),
    .o_ready (ready),
    .o_val   (val),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] target;
    logic [3:0] step;
    logic [7:0] hold;
    int         first;
    int         n;
    int         ticks;
    int         final_v;
    bit         noise;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock; also tracks the expected period counter and whether this edge was a tick.
  task automatic clk1();
    bit was_tick;
    bit was_rst;
    was_tick = (tb_cnt == 1023);
    was_rst  = rst;
    @(posedge clk);
    #1;
    tb_cnt    = was_rst ? 0 : (tb_cnt + 1) % 1024;
    last_tick = was_tick && !was_rst;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int ticks;
    int prev;
    bit seen;
    chk($sformatf("v%0d_ready_before", idx), ready, 1);
    prev   = val;
    target = v.target;
    step   = v.step;
    hold   = v.hold;
    valid  = 1'b1;
    clk1();
    valid  = 1'b0;
    if (v.n == 0) begin
      chk($sformatf("v%0d_eq_done", idx), done, 1);
      chk($sformatf("v%0d_eq_busy", idx), busy, 0);
      chk($sformatf("v%0d_eq_ready", idx), ready, 1);
      chk($sformatf("v%0d_eq_val", idx), val, v.final_v);
      clk1();
      chk($sformatf("v%0d_eq_done_single", idx), done, 0);
      chk($sformatf("v%0d_eq_busy_after", idx), busy, 0);
      return;
    end
    chk($sformatf("v%0d_busy_start", idx), busy, 1);
    chk($sformatf("v%0d_ready_start", idx), ready, 0);
    chk($sformatf("v%0d_done_start", idx), done, 0);
    n     = 0;
    ticks = 0;
    seen  = 1'b0;
    for (int c = 0; c < (v.ticks + 1) * 1024 + 16 && !seen; c++) begin
      if (v.noise && n < 3) begin
        valid  = 1'b1;
        target = 10'd500;
      end else begin
        valid = 1'b0;
      end
      clk1();
      if (last_tick) ticks++;
      if (val != prev[9:0]) begin
        n++;
        chk($sformatf("v%0d_change_on_tick", idx), last_tick, 1);
        if (n == 1) chk($sformatf("v%0d_first", idx), val, v.first);
        prev = val;
      end
      if (done) begin
        seen = 1'b1;
        chk($sformatf("v%0d_final", idx), val, v.final_v);
        chk($sformatf("v%0d_n_steps", idx), n, v.n);
        chk($sformatf("v%0d_ticks", idx), ticks, v.ticks);
        chk($sformatf("v%0d_busy_end", idx), busy, 0);
        chk($sformatf("v%0d_ready_end", idx), ready, 1);
      end
    end
    valid = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), seen, 1);
    clk1();
    chk($sformatf("v%0d_done_single", idx), done, 0);
    chk($sformatf("v%0d_val_hold", idx), val, v.final_v);
  endtask

  initial begin
    bit hit;
    vecs[0] = '{10'd3,    4'd0,  8'd0, 1,    3,  3,  3,    1'b0};
    vecs[1] = '{10'd3,    4'd5,  8'd0, 0,    0,  0,  3,    1'b0};
    vecs[2] = '{10'd0,    4'd15, 8'd0, 0,    1,  1,  0,    1'b0};
    vecs[3] = '{10'd6,    4'd2,  8'd2, 2,    3,  9,  6,    1'b0};
    vecs[4] = '{10'd1023, 4'd15, 8'd0, 21,   68, 68, 1023, 1'b1};
    vecs[5] = '{10'd1013, 4'd10, 8'd0, 1013, 1,  1,  1013, 1'b0};

    rst    = 1'b1;
    valid  = 1'b0;
    target = '0;
    step   = '0;
    hold   = '0;
    clk1();
    clk1();
    rst = 1'b0;
    chk("rst_val", val, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Reset in the middle of a ramp, once the output has reached 40.
    target = 10'd100;
    step   = 4'd10;
    hold   = 8'd0;
    valid  = 1'b1;
    clk1();
    valid = 1'b0;
    hit   = 1'b0;
    for (int c = 0; c < 5 * 1024 && !hit; c++) begin
      clk1();
      if (val == 10'd40) hit = 1'b1;
    end
    chk("midramp_reach40", hit, 1);
    chk("midramp_busy", busy, 1);
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    chk("midramp_rst_val", val, 0);
    chk("midramp_rst_ready", ready, 1);
    chk("midramp_rst_busy", busy, 0);
    chk("midramp_rst_done", done, 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/drv_pwm_ramp.md
Name: drv_pwm_ramp

Overview:
Duty-value sequencer that sits directly upstream of the PWM output driver and produces its duty value.
- Accepts a target duty via a valid/ready handshake.
- Ramps its output from the current value to the target in fixed steps, with a programmable number of PWM periods between steps.
- Updates its output only at PWM period boundaries, so the downstream driver never sees a mid-period change.
- Typical uses: soft start and LED/motor fades.

Parameters:
p_depth, 10, duty/period counter width; must equal the downstream PWM driver's depth; period = 2^p_depth clocks.
p_step_w, 4, width of step-size input.
p_hold_w, 8, width of hold (periods-per-step) input.

Ports:
i_clk  input  1  clock.
i_rst  input  1  synchronous reset, active-high.
i_target  input  p_depth  requested final duty value.
i_step  input  p_step_w  increment per step; 0 is treated as 1.
i_hold  input  p_hold_w  extra periods between steps; 0 means a step every period.
i_valid  input  1  request strobe.
o_ready  output  1  high when a request can be accepted.
o_val  output  p_depth  duty value; connects to the PWM driver's duty input.
o_busy  output  1  high while ramping.
o_done  output  1  one-cycle pulse when o_val reaches the target.

Behaviour:
- Reset (synchronous, active-high, any state including mid-ramp), applied on the next clock edge:
  - o_val=0, o_busy=0, o_done=0, state=IDLE.
  - Period counter=0, hold counter=0.
  - o_ready=1 from the first cycle after reset deasserts.
- Period counter:
  - Free-running, p_depth bits, +1 every clock, wraps 2^p_depth-1 -> 0.
  - tick = (counter == all ones).
  - Reset together with the PWM driver, so a tick is the last cycle of each PWM period.
- o_val is registered and changes only on a tick edge. The driver therefore sees the new value from its count 0 onward.
- Handshake: a transfer occurs when i_valid && o_ready.
  - o_ready = (state == IDLE), decoded from registered state.
  - i_valid is ignored outside IDLE; there is no queueing and no abort.
- Transfer latches target, step (0 -> 1) and hold, and clears the hold counter. Then:
  - If target == o_val: o_done=1 on the next cycle, state stays IDLE, o_busy stays 0.
  - Otherwise: state -> RAMP, and o_busy=1 from the next cycle.
- RAMP state: o_ready=0, o_busy=1. On each tick:
  - If hold_cnt < hold: hold_cnt += 1.
  - Otherwise: hold_cnt <= 0 and one step is applied.
- Step rules:
  - Distance computed as |target − o_val| with p_depth+1-bit arithmetic.
  - If distance <= step: o_val <= target, state -> IDLE, o_done=1 in the same cycle o_val first equals target.
  - Otherwise: o_val <= o_val ± step toward target.
  - No overshoot and no wrap, e.g. a ramp ending at all ones or at 0 never wraps.
- Timing:
  - First step occurs at the (hold+1)-th tick strictly after the transfer cycle.
  - A tick coincident with the transfer cycle does not count.
  - Steps are then spaced (hold+1)·2^p_depth clocks apart.
- After o_done: o_busy=0 and o_ready=1 in the same cycle; a new request can transfer on that cycle.
- o_done is high for exactly one clock per completed request.

Test Plan:
All scenarios use p_depth=10, i.e. a 1024-clock period, with the first tick at cycle 1023 after reset release.
- Reset -> o_val=0, o_ready=1, o_busy=0, o_done=0. Assert i_rst mid-ramp at o_val=40 -> next cycle o_val=0, IDLE, o_ready=1.
- Up ramp: from 0, target=100, step=10, hold=0, transfer at cycle 5 -> o_val=10,20,…,100 at ticks 1023, 2047, …, 10239. o_done pulses once with o_val=100; o_busy low and o_ready high from then.
- Clamp down: from 100, target=95, step=10, hold=0 -> single step to 95 at the next tick, o_done pulse. From 1020, target=1023, step=15 -> o_val=1023, no wrap.
- Hold: from 0, target=6, step=2, hold=2 -> updates only on every 3rd tick (ticks 3, 6, 9 after transfer): 2, 4, 6.
- Edge requests:
  - step=0, target=3 -> steps of 1 (1, 2, 3).
  - target equal to o_val -> o_done the next cycle, o_busy never high.
  - i_valid with a new target during RAMP -> ignored; original target reached unchanged.
- Boundary alignment: check o_val changes only on clocks where the period counter is 1023, across a full 0 -> 1023 -> 0 ramp with step=15.
